// File: rtl/rb_alu_ctrl_if.sv
// Command, register-bank and status signals of the rb_alu_ctrl block.
// The master side is the upstream stimulus together with the bank read data;
// the slave side is the controller itself.
interface rb_alu_ctrl_if #(
  parameter int unsigned W = 7,
  parameter int unsigned N = 2
);
  localparam int unsigned AW = 2 ** N;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [W-1:0]  cmd_imm;
  logic          rb_we;
  logic [AW-1:0] rb_addr_rd;
  logic [AW-1:0] rb_addr_rs1;
  logic [AW-1:0] rb_addr_rs2;
  logic [W-1:0]  rb_data_in;
  logic [W-1:0]  rb_rs1;
  logic [W-1:0]  rb_rs2;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rb_rs1, rb_rs2,
    input  cmd_ready, rb_we, rb_addr_rd, rb_addr_rs1, rb_addr_rs2, rb_data_in,
    input  done, err, result, carry, zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rb_rs1, rb_rs2,
    output cmd_ready, rb_we, rb_addr_rd, rb_addr_rs1, rb_addr_rs2, rb_data_in,
    output done, err, result, carry, zero
  );
endinterface

// File: rtl/rb_alu_ctrl.sv
// Command sequencer/ALU in front of the register bank. One command takes
// IDLE -> READ -> EXEC -> WRITE -> IDLE; all outputs are registered.
module rb_alu_ctrl #(
  parameter int unsigned W = 7,
  parameter int unsigned N = 2
) (
  input logic          clk,
  input logic          reset,
  rb_alu_ctrl_if.slave bus
);
  localparam int unsigned AW      = 2 ** N;
  localparam int unsigned NumRegs = 2 ** N;

  typedef enum logic [2:0] {
    OpAdd   = 3'b000,
    OpSub   = 3'b001,
    OpAnd   = 3'b010,
    OpOr    = 3'b011,
    OpXor   = 3'b100,
    OpSll   = 3'b101,
    OpLoadi = 3'b110,
    OpRsvd  = 3'b111
  } op_e;

  typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

  state_e        state_q;
  op_e           op_q;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  opa_q;
  logic [W-1:0]  opb_q;
  logic [W-1:0]  alu_q;
  logic          alu_carry_q;

  logic          cmd_ready_q;
  logic          rb_we_q;
  logic [AW-1:0] rb_addr_rd_q;
  logic [AW-1:0] rb_addr_rs1_q;
  logic [AW-1:0] rb_addr_rs2_q;
  logic [W-1:0]  rb_data_in_q;
  logic          done_q;
  logic          err_q;
  logic [W-1:0]  result_q;
  logic          carry_q;
  logic          zero_q;

  logic          cmd_ok;
  logic [W:0]    alu_wide;
  logic [W-1:0]  alu_res;
  logic          alu_c;

  // Legality of the presented command; LOADI ignores its source addresses.
  always_comb begin
    cmd_ok = (bus.cmd_op != OpRsvd) && (32'(bus.cmd_rd) < NumRegs);
    if (bus.cmd_op != OpLoadi) begin
      cmd_ok = cmd_ok && (32'(bus.cmd_rs1) < NumRegs) && (32'(bus.cmd_rs2) < NumRegs);
    end
  end

  // ALU on the operands captured in READ; carry is carry-out for ADD, borrow for SUB.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_wide = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      OpSub: begin
        alu_wide = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res  = alu_wide[W-1:0];
        alu_c    = alu_wide[W];
      end
      OpAnd:   alu_res = opa_q & opb_q;
      OpOr:    alu_res = opa_q | opb_q;
      OpXor:   alu_res = opa_q ^ opb_q;
      OpSll:   alu_res = (32'(opb_q) >= W) ? '0 : (opa_q << opb_q);
      OpLoadi: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  // Sequencer FSM with registered bank and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= OpAdd;
      rd_q          <= '0;
      imm_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      alu_q         <= '0;
      alu_carry_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rb_we_q       <= 1'b0;
      rb_addr_rd_q  <= '0;
      rb_addr_rs1_q <= '0;
      rb_addr_rs2_q <= '0;
      rb_data_in_q  <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            if (cmd_ok) begin
              op_q          <= op_e'(bus.cmd_op);
              rd_q          <= bus.cmd_rd;
              imm_q         <= bus.cmd_imm;
              rb_addr_rs1_q <= bus.cmd_rs1;
              rb_addr_rs2_q <= bus.cmd_rs2;
              cmd_ready_q   <= 1'b0;
              state_q       <= StRead;
            end else begin
              // Rejected commands are consumed but never reach the bank.
              err_q <= 1'b1;
            end
          end
        end
        StRead: begin
          opa_q         <= bus.rb_rs1;
          opb_q         <= bus.rb_rs2;
          rb_addr_rs1_q <= '0;
          rb_addr_rs2_q <= '0;
          state_q       <= StExec;
        end
        StExec: begin
          alu_q        <= alu_res;
          alu_carry_q  <= alu_c;
          // Register 0 is never written.
          rb_we_q      <= (rd_q != '0);
          rb_addr_rd_q <= rd_q;
          rb_data_in_q <= alu_res;
          state_q      <= StWrite;
        end
        StWrite: begin
          rb_we_q      <= 1'b0;
          rb_addr_rd_q <= '0;
          rb_data_in_q <= '0;
          result_q     <= alu_q;
          carry_q      <= alu_carry_q;
          zero_q       <= (alu_q == '0);
          done_q       <= 1'b1;
          cmd_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rb_we       = rb_we_q;
  assign bus.rb_addr_rd  = rb_addr_rd_q;
  assign bus.rb_addr_rs1 = rb_addr_rs1_q;
  assign bus.rb_addr_rs2 = rb_addr_rs2_q;
  assign bus.rb_data_in  = rb_data_in_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.zero        = zero_q;
endmodule

// File: tb/tb_rb_alu_ctrl.sv
// Directed bench for rb_alu_ctrl with a small register-bank model.
module tb_rb_alu_ctrl;
  localparam int unsigned W       = 7;
  localparam int unsigned N       = 2;
  localparam int unsigned AW      = 2 ** N;
  localparam int unsigned NumRegs = 2 ** N;

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpSub   = 3'b001;
  localparam logic [2:0] OpAnd   = 3'b010;
  localparam logic [2:0] OpOr    = 3'b011;
  localparam logic [2:0] OpXor   = 3'b100;
  localparam logic [2:0] OpSll   = 3'b101;
  localparam logic [2:0] OpLoadi = 3'b110;
  localparam logic [2:0] OpRsvd  = 3'b111;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [W-1:0]  imm;
    logic          err;
    logic [W-1:0]  res;
    logic          c;
    logic          z;
    logic          we;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] bank [NumRegs] = '{default: '0};
  int           w3_cnt = 0;
  logic [W-1:0] last_res = '0;

  vec_t vecs [15];

  rb_alu_ctrl_if #(.W(W), .N(N)) bus ();

  rb_alu_ctrl #(.W(W), .N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Bank model: combinational reads, write on the clock edge.
  assign bus.rb_rs1 = bank[bus.rb_addr_rs1[N-1:0]];
  assign bus.rb_rs2 = bank[bus.rb_addr_rs2[N-1:0]];

  always @(posedge clk) begin
    if (bus.rb_we) begin
      bank[bus.rb_addr_rd[N-1:0]] <= bus.rb_data_in;
      if (bus.rb_addr_rd == AW'(3)) w3_cnt <= w3_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                              input int imm, input logic e, input int r, input logic c,
                              input logic z, input logic we);
    vec_t v;
    v.op  = op;
    v.rd  = AW'(rd);
    v.rs1 = AW'(rs1);
    v.rs2 = AW'(rs2);
    v.imm = W'(imm);
    v.err = e;
    v.res = W'(r);
    v.c   = c;
    v.z   = z;
    v.we  = we;
    return v;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [W-1:0] imm);
    bus.cmd_op  = op;
    bus.cmd_rd  = rd;
    bus.cmd_rs1 = rs1;
    bus.cmd_rs2 = rs2;
    bus.cmd_imm = imm;
  endtask

  // Apply one table entry and follow it cycle by cycle until it completes.
  task automatic run_vec(input int i);
    vec_t v;
    int   stray;
    v = vecs[i];
    @(negedge clk);
    chk($sformatf("v%0d ready_c0", i), bus.cmd_ready, 1);
    drive(v.op, v.rd, v.rs1, v.rs2, v.imm);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk($sformatf("v%0d err_c1", i), bus.err, v.err);
    if (v.err) begin
      chk($sformatf("v%0d ready_c1", i), bus.cmd_ready, 1);
      chk($sformatf("v%0d result_held", i), bus.result, last_res);
      stray = (bus.done || bus.rb_we) ? 1 : 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.done || bus.rb_we || bus.err) stray++;
      end
      chk($sformatf("v%0d stray_pulses", i), stray, 0);
    end else begin
      chk($sformatf("v%0d ready_c1", i), bus.cmd_ready, 0);
      chk($sformatf("v%0d rs1_addr_c1", i), bus.rb_addr_rs1, v.rs1);
      chk($sformatf("v%0d rs2_addr_c1", i), bus.rb_addr_rs2, v.rs2);
      @(negedge clk);
      chk($sformatf("v%0d we_c2", i), bus.rb_we, 0);
      chk($sformatf("v%0d rs1_addr_c2", i), bus.rb_addr_rs1, 0);
      @(negedge clk);
      chk($sformatf("v%0d we_c3", i), bus.rb_we, v.we);
      chk($sformatf("v%0d addr_rd_c3", i), bus.rb_addr_rd, v.rd);
      chk($sformatf("v%0d data_in_c3", i), bus.rb_data_in, v.res);
      chk($sformatf("v%0d done_c3", i), bus.done, 0);
      chk($sformatf("v%0d result_c3", i), bus.result, last_res);
      @(negedge clk);
      chk($sformatf("v%0d done_c4", i), bus.done, 1);
      chk($sformatf("v%0d result", i), bus.result, v.res);
      chk($sformatf("v%0d carry", i), bus.carry, v.c);
      chk($sformatf("v%0d zero", i), bus.zero, v.z);
      chk($sformatf("v%0d ready_c4", i), bus.cmd_ready, 1);
      chk($sformatf("v%0d we_c4", i), bus.rb_we, 0);
      if (v.we) chk($sformatf("v%0d bank_rd", i), bank[v.rd[N-1:0]], v.res);
      else      chk($sformatf("v%0d bank_r0", i), bank[0], 0);
      last_res = v.res;
    end
  endtask

  initial begin
    int            w3_start;
    int            dn;
    int            idx;
    int            acc_t [$];
    logic [W-1:0]  done_res [$];
    logic [W-1:0]  b2b_exp [3];

    vecs[0]  = mk(OpLoadi, 1, 0, 0, 'h05, 0, 'h05, 0, 0, 1);
    vecs[1]  = mk(OpLoadi, 2, 0, 0, 'h7E, 0, 'h7E, 0, 0, 1);
    vecs[2]  = mk(OpAdd,   3, 1, 2, 0,    0, 'h03, 1, 0, 1);
    vecs[3]  = mk(OpSub,   3, 1, 2, 0,    0, 'h07, 1, 0, 1);
    vecs[4]  = mk(OpSub,   3, 2, 2, 0,    0, 'h00, 0, 1, 1);
    vecs[5]  = mk(OpSll,   3, 1, 2, 0,    0, 'h00, 0, 1, 1);
    vecs[6]  = mk(OpAdd,   0, 1, 2, 0,    0, 'h03, 1, 0, 0);
    vecs[7]  = mk(OpAnd,   3, 1, 2, 0,    0, 'h04, 0, 0, 1);
    vecs[8]  = mk(OpOr,    3, 1, 2, 0,    0, 'h7F, 0, 0, 1);
    vecs[9]  = mk(OpXor,   3, 1, 2, 0,    0, 'h7B, 0, 0, 1);
    vecs[10] = mk(OpSll,   3, 1, 1, 0,    0, 'h20, 0, 0, 1);
    vecs[11] = mk(OpAdd,   3, 4, 2, 0,    1, 'h20, 0, 0, 0);
    vecs[12] = mk(OpRsvd,  3, 1, 2, 0,    1, 'h20, 0, 0, 0);
    vecs[13] = mk(OpLoadi, 1, 15, 9, 'h11, 0, 'h11, 0, 0, 1);
    vecs[14] = mk(OpLoadi, 4, 0, 0, 'h22, 1, 'h11, 0, 0, 0);

    bus.cmd_valid = 1'b0;
    drive(3'b000, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset ready", bus.cmd_ready, 1);
    chk("reset done", bus.done, 0);
    chk("reset err", bus.err, 0);
    chk("reset we", bus.rb_we, 0);
    chk("reset result", bus.result, 0);
    chk("reset rs1_addr", bus.rb_addr_rs1, 0);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Reset during EXEC aborts the command without a write.
    @(negedge clk);
    w3_start = w3_cnt;
    drive(OpAdd, AW'(3), AW'(1), AW'(2), '0);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort ready", bus.cmd_ready, 1);
    chk("abort we", bus.rb_we, 0);
    chk("abort done", bus.done, 0);
    chk("abort result", bus.result, 0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    chk("abort late_done", dn, 0);
    chk("abort no_w3", w3_cnt, w3_start);

    // Reset together with cmd_valid: the command must not be taken.
    drive(OpAdd, AW'(3), AW'(2), AW'(1), '0);
    bus.cmd_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("rstvalid ready", bus.cmd_ready, 1);
    chk("rstvalid rs1_addr", bus.rb_addr_rs1, 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.rb_we) dn++;
    end
    chk("rstvalid no_activity", dn, 0);

    // Back-to-back: valid held high, garbage on cmd_* while busy.
    b2b_exp[0] = 7'h0A;
    b2b_exp[1] = 7'h15;
    b2b_exp[2] = 7'h1F;
    idx = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (bus.done) done_res.push_back(bus.result);
      if (bus.cmd_ready && idx < 3) begin
        acc_t.push_back(t);
        unique case (idx)
          0:       drive(OpLoadi, AW'(1), AW'(0), AW'(0), 7'h0A);
          1:       drive(OpLoadi, AW'(2), AW'(0), AW'(0), 7'h15);
          default: drive(OpAdd,   AW'(3), AW'(1), AW'(2), 7'h00);
        endcase
        bus.cmd_valid = 1'b1;
        idx++;
      end else if (bus.cmd_ready) begin
        bus.cmd_valid = 1'b0;
      end else begin
        drive(OpLoadi, AW'(2), AW'(3), AW'(3), W'(t * 9 + 1));
      end
    end
    bus.cmd_valid = 1'b0;
    chk("b2b accepts", acc_t.size(), 3);
    if (acc_t.size() == 3) begin
      chk("b2b first", acc_t[0], 0);
      chk("b2b gap1", acc_t[1] - acc_t[0], 4);
      chk("b2b gap2", acc_t[2] - acc_t[1], 4);
    end
    chk("b2b dones", done_res.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < done_res.size()) chk($sformatf("b2b result%0d", k), done_res[k], b2b_exp[k]);
    end
    chk("b2b bank1", bank[1], 7'h0A);
    chk("b2b bank2", bank[2], 7'h15);
    chk("b2b bank3", bank[3], 7'h1F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
